// File: rtl/tpu_sram_loader.sv
// Stream-to-SRAM loader for the systolic subarray: fills weight banks w0/w1 (two beats per word)
// and data banks d0/d1 (one beat per word) in order, then kicks the subarray and waits for it to finish.
module tpu_sram_loader #(
  parameter int IN_WIDTH          = 32,
  parameter int SRAM_DATA_WIDTH   = 32,
  parameter int SRAM_WEIGHT_WIDTH = 64,
  parameter int W_WORDS           = 64,
  parameter int D_WORDS           = 128
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         load_start,
  input  logic                         in_valid,
  input  logic [IN_WIDTH-1:0]          in_data,
  output logic                         in_ready,
  output logic                         sram_write_enable_w0,
  output logic                         sram_write_enable_w1,
  output logic [SRAM_WEIGHT_WIDTH-1:0] sram_wdata_w,
  output logic [9:0]                   sram_waddr_w,
  output logic                         sram_write_enable_d0,
  output logic                         sram_write_enable_d1,
  output logic [SRAM_DATA_WIDTH-1:0]   sram_wdata_d,
  output logic [9:0]                   sram_waddr_d,
  output logic                         tpu_start,
  input  logic                         tpu_done,
  output logic                         busy,
  output logic                         load_done
);

  typedef enum logic [2:0] {IDLE, LD_W0, LD_W1, LD_D0, LD_D1, KICK, WAIT} state_t;

  localparam logic [9:0] W_LAST = 10'(W_WORDS - 1);
  localparam logic [9:0] D_LAST = 10'(D_WORDS - 1);

  state_t              state_reg;
  logic [9:0]          cnt_reg;
  logic                half_reg;
  logic [IN_WIDTH-1:0] pack_reg;
  logic                beat_hs;

  assign in_ready = (state_reg == LD_W0) || (state_reg == LD_W1) ||
                    (state_reg == LD_D0) || (state_reg == LD_D1);
  assign busy     = (state_reg != IDLE);
  assign beat_hs  = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg            <= IDLE;
      cnt_reg              <= '0;
      half_reg             <= 1'b0;
      pack_reg             <= '0;
      sram_write_enable_w0 <= 1'b0;
      sram_write_enable_w1 <= 1'b0;
      sram_wdata_w         <= '0;
      sram_waddr_w         <= '0;
      sram_write_enable_d0 <= 1'b0;
      sram_write_enable_d1 <= 1'b0;
      sram_wdata_d         <= '0;
      sram_waddr_d         <= '0;
      tpu_start            <= 1'b0;
      load_done            <= 1'b0;
    end else begin
      // Strobes and pulses default low; wdata/waddr keep their last value.
      sram_write_enable_w0 <= 1'b0;
      sram_write_enable_w1 <= 1'b0;
      sram_write_enable_d0 <= 1'b0;
      sram_write_enable_d1 <= 1'b0;
      tpu_start            <= 1'b0;
      load_done            <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (load_start) begin
            state_reg <= LD_W0;
            cnt_reg   <= '0;
            half_reg  <= 1'b0;
          end
        end

        LD_W0, LD_W1: begin
          if (beat_hs) begin
            if (!half_reg) begin
              pack_reg <= in_data;
              half_reg <= 1'b1;
            end else begin
              half_reg             <= 1'b0;
              sram_wdata_w         <= {pack_reg, in_data};
              sram_waddr_w         <= cnt_reg;
              sram_write_enable_w0 <= (state_reg == LD_W0);
              sram_write_enable_w1 <= (state_reg == LD_W1);
              if (cnt_reg == W_LAST) begin
                cnt_reg   <= '0;
                state_reg <= (state_reg == LD_W0) ? LD_W1 : LD_D0;
              end else begin
                cnt_reg <= cnt_reg + 10'd1;
              end
            end
          end
        end

        LD_D0, LD_D1: begin
          if (beat_hs) begin
            sram_wdata_d         <= in_data;
            sram_waddr_d         <= cnt_reg;
            sram_write_enable_d0 <= (state_reg == LD_D0);
            sram_write_enable_d1 <= (state_reg == LD_D1);
            if (cnt_reg == D_LAST) begin
              cnt_reg <= '0;
              if (state_reg == LD_D0) begin
                state_reg <= LD_D1;
              end else begin
                // Start pulse lines up with the final data strobe.
                state_reg <= KICK;
                tpu_start <= 1'b1;
              end
            end else begin
              cnt_reg <= cnt_reg + 10'd1;
            end
          end
        end

        KICK: state_reg <= WAIT;

        WAIT: begin
          if (tpu_done) begin
            load_done <= 1'b1;
            state_reg <= IDLE;
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
